// File: rtl/text_pkg.sv
// Shared character codes and FSM state type for the on-screen text writer.
package text_pkg;

  localparam logic [7:0] CHAR_BS    = 8'h08;
  localparam logic [7:0] CHAR_LF    = 8'h0A;
  localparam logic [7:0] CHAR_FF    = 8'h0C;
  localparam logic [7:0] CHAR_CR    = 8'h0D;
  localparam logic [7:0] CHAR_SPACE = 8'h20;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

endpackage

// File: rtl/text_cursor_ctr.sv
// X/Y cell cursor with inc/dec/cr/lf/home controls; wraps by explicit compare,
// so non-power-of-two table sizes work. Priority: home > inc > dec > cr > lf.
module text_cursor_ctr #(
  parameter int COLUMNS = 12,
  parameter int ROWS    = 2
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       inc,
  input  logic                       dec,
  input  logic                       cr,
  input  logic                       lf,
  input  logic                       home,
  output logic [$clog2(COLUMNS)-1:0] x,
  output logic [$clog2(ROWS)-1:0]    y
);

  localparam int XW = $clog2(COLUMNS);
  localparam int YW = $clog2(ROWS);
  localparam logic [XW-1:0] X_LAST = XW'(COLUMNS - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(ROWS - 1);

  logic [YW-1:0] y_next_row;

  assign y_next_row = (y == Y_LAST) ? '0 : y + 1'b1;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      x <= '0;
      y <= '0;
    end else if (home) begin
      x <= '0;
      y <= '0;
    end else if (inc) begin
      if (x == X_LAST) begin
        x <= '0;
        y <= y_next_row;
      end else begin
        x <= x + 1'b1;
      end
    end else if (dec) begin
      // Backspace stops at column 0 and never crosses rows
      if (x != '0) x <= x - 1'b1;
    end else if (cr) begin
      x <= '0;
    end else if (lf) begin
      x <= '0;
      y <= y_next_row;
    end
  end

endmodule

// File: rtl/text_cursor_writer.sv
// Character stream -> text table write port with cursor, control codes and full-screen clear.
// Writes are registered (1 cycle); o_ready drops during clear. Optional CLEAR_ON_RESET_EN blanks the table after reset.
module text_cursor_writer
  import text_pkg::*;
#(
  parameter int COLUMNS       = 12,
  parameter int ROWS          = 2,
  parameter int FONT_NUM_CHAR = 256
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic [$clog2(FONT_NUM_CHAR)-1:0] i_char,
  input  logic                             i_char_dv,
  output logic                             o_ready,
  output logic [$clog2(FONT_NUM_CHAR)-1:0] o_wr_character,
  output logic [$clog2(COLUMNS)-1:0]       o_wr_x_pos,
  output logic [$clog2(ROWS)-1:0]          o_wr_y_pos,
  output logic                             o_wr_en,
  output logic [$clog2(COLUMNS)-1:0]       o_cursor_x,
  output logic [$clog2(ROWS)-1:0]          o_cursor_y,
  output logic                             o_busy
);

  localparam int CW    = $clog2(FONT_NUM_CHAR);
  localparam int XW    = $clog2(COLUMNS);
  localparam int YW    = $clog2(ROWS);
  localparam int CELLS = COLUMNS * ROWS;
  localparam int IW    = $clog2(CELLS);
  localparam logic [IW-1:0] LAST_CELL = IW'(CELLS - 1);

`ifdef CLEAR_ON_RESET_EN
  localparam state_t RST_STATE = CLEAR;
`else
  localparam state_t RST_STATE = IDLE;
`endif

  state_t        state, state_nxt;
  logic          accept, clr_step, clr_last;
  logic          is_bs, is_lf, is_ff, is_cr, is_print;
  logic          cur_inc, cur_dec, cur_cr, cur_lf, cur_home;
  logic [XW-1:0] clr_x;
  logic [YW-1:0] clr_y;
  logic [IW-1:0] clr_idx;

  assign is_bs    = (i_char == CW'(CHAR_BS));
  assign is_lf    = (i_char == CW'(CHAR_LF));
  assign is_ff    = (i_char == CW'(CHAR_FF));
  assign is_cr    = (i_char == CW'(CHAR_CR));
  assign is_print = !(is_bs || is_lf || is_ff || is_cr);
  assign clr_last = (clr_idx == LAST_CELL);

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= RST_STATE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && is_ff) state_nxt = CLEAR;
      CLEAR:   if (clr_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_ready  = 1'b0;
    o_busy   = 1'b0;
    clr_step = 1'b0;
    case (state)
      IDLE:  o_ready = !i_rst;
      CLEAR: begin
        o_busy   = !i_rst;
        clr_step = 1'b1;
      end
      default: ;
    endcase
    accept   = o_ready && i_char_dv;
    cur_inc  = accept && is_print;
    cur_dec  = accept && is_bs && (o_cursor_x != '0);
    cur_cr   = accept && is_cr;
    cur_lf   = accept && is_lf;
    cur_home = clr_step && clr_last;
  end

  text_cursor_ctr #(.COLUMNS(COLUMNS), .ROWS(ROWS)) u_cursor (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .inc   (cur_inc),
    .dec   (cur_dec),
    .cr    (cur_cr),
    .lf    (cur_lf),
    .home  (cur_home),
    .x     (o_cursor_x),
    .y     (o_cursor_y)
  );

  // Second counter walks the clear in row-major order and wraps back to (0,0) on its own
  text_cursor_ctr #(.COLUMNS(COLUMNS), .ROWS(ROWS)) u_clear_walk (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .inc   (clr_step),
    .dec   (1'b0),
    .cr    (1'b0),
    .lf    (1'b0),
    .home  (accept && is_ff),
    .x     (clr_x),
    .y     (clr_y)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_wr_en        <= 1'b0;
      o_wr_character <= '0;
      o_wr_x_pos     <= '0;
      o_wr_y_pos     <= '0;
      clr_idx        <= '0;
    end else begin
      o_wr_en <= 1'b0;
      if (clr_step) begin
        o_wr_en        <= 1'b1;
        o_wr_character <= CW'(CHAR_SPACE);
        o_wr_x_pos     <= clr_x;
        o_wr_y_pos     <= clr_y;
        clr_idx        <= clr_last ? '0 : clr_idx + 1'b1;
      end else if (cur_inc) begin
        o_wr_en        <= 1'b1;
        o_wr_character <= i_char;
        o_wr_x_pos     <= o_cursor_x;
        o_wr_y_pos     <= o_cursor_y;
      end else if (cur_dec) begin
        o_wr_en        <= 1'b1;
        o_wr_character <= CW'(CHAR_SPACE);
        o_wr_x_pos     <= o_cursor_x - 1'b1;
        o_wr_y_pos     <= o_cursor_y;
      end
    end
  end

endmodule

// File: tb/tb_text_cursor_writer.sv
// Directed bench for text_cursor_writer (12x2 table); honours CLEAR_ON_RESET_EN when defined.
module tb_text_cursor_writer;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic [7:0] i_char = 8'h00;
  logic       i_char_dv = 1'b0;
  logic       o_ready, o_wr_en, o_busy;
  logic [7:0] o_wr_character;
  logic [3:0] o_wr_x_pos, o_cursor_x;
  logic [0:0] o_wr_y_pos, o_cursor_y;

  int total = 0;
  int bad   = 0;

  always #5 i_clk = ~i_clk;

  text_cursor_writer #(.COLUMNS(12), .ROWS(2), .FONT_NUM_CHAR(256)) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_char         (i_char),
    .i_char_dv      (i_char_dv),
    .o_ready        (o_ready),
    .o_wr_character (o_wr_character),
    .o_wr_x_pos     (o_wr_x_pos),
    .o_wr_y_pos     (o_wr_y_pos),
    .o_wr_en        (o_wr_en),
    .o_cursor_x     (o_cursor_x),
    .o_cursor_y     (o_cursor_y),
    .o_busy         (o_busy)
  );

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic send(input logic [7:0] c);
    i_char    = c;
    i_char_dv = 1'b1;
    tick();
    i_char_dv = 1'b0;
  endtask

  task automatic check_wr(input string tag, input int en, input int ch, input int x, input int y);
    chk({tag, "_en"}, o_wr_en, en);
    if (en == 1) begin
      chk({tag, "_chr"}, o_wr_character, ch);
      chk({tag, "_x"}, o_wr_x_pos, x);
      chk({tag, "_y"}, o_wr_y_pos, y);
    end
  endtask

  task automatic check_cur(input string tag, input int x, input int y);
    chk({tag, "_cx"}, o_cursor_x, x);
    chk({tag, "_cy"}, o_cursor_y, y);
  endtask

  // Entered with the block already in CLEAR and no write yet issued
  task automatic expect_clear(input string tag);
    chk({tag, "_rdy0"}, o_ready, 0);
    chk({tag, "_busy0"}, o_busy, 1);
    chk({tag, "_en0"}, o_wr_en, 0);
    for (int k = 0; k < 24; k++) begin
      tick();
      check_wr(tag, 1, 'h20, k % 12, k / 12);
      if (k < 23) begin
        chk({tag, "_rdy"}, o_ready, 0);
      end else begin
        chk({tag, "_rdy_end"}, o_ready, 1);
        chk({tag, "_busy_end"}, o_busy, 0);
        check_cur({tag, "_end"}, 0, 0);
      end
    end
  endtask

  task automatic do_reset();
    i_rst     = 1'b1;
    i_char_dv = 1'b0;
    tick();
    tick();
    chk("rst_rdy", o_ready, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_en", o_wr_en, 0);
    chk("rst_chr", o_wr_character, 0);
    chk("rst_wx", o_wr_x_pos, 0);
    chk("rst_wy", o_wr_y_pos, 0);
    check_cur("rst", 0, 0);
    i_rst = 1'b0;
    #1;
`ifdef CLEAR_ON_RESET_EN
    expect_clear("por_clr");
`else
    chk("rel_rdy", o_ready, 1);
    chk("rel_busy", o_busy, 0);
`endif
  endtask

  initial begin
    do_reset();

    // Single printable character
    chk("t1_rdy", o_ready, 1);
    send(8'h41);
    check_wr("t1", 1, 'h41, 0, 0);
    check_cur("t1", 1, 0);
    tick();
    chk("t1_pulse", o_wr_en, 0);

    // 25 back-to-back characters wrap the whole table
    do_reset();
    i_char_dv = 1'b1;
    for (int i = 0; i < 25; i++) begin
      i_char = 8'(8'h30 + i);
      chk("t2_rdy", o_ready, 1);
      tick();
      check_wr("t2", 1, 'h30 + i, i % 12, (i / 12) % 2);
    end
    i_char_dv = 1'b0;
    check_cur("t2", 1, 0);

    // CR and LF from (5,1)
    for (int i = 0; i < 16; i++) send(8'h61);
    check_cur("t3_pre", 5, 1);
    send(8'h0D);
    chk("t3_cr_en", o_wr_en, 0);
    check_cur("t3_cr", 0, 1);
    send(8'h0A);
    chk("t3_lf_en", o_wr_en, 0);
    check_cur("t3_lf", 0, 0);

    // Backspace mid-row, then at column 0
    for (int i = 0; i < 3; i++) send(8'h42);
    check_cur("t4_pre", 3, 0);
    send(8'h08);
    check_wr("t4_bs", 1, 'h20, 2, 0);
    check_cur("t4_bs", 2, 0);
    send(8'h0A);
    check_cur("t4_lf", 0, 1);
    send(8'h08);
    chk("t4_bs0_en", o_wr_en, 0);
    check_cur("t4_bs0", 0, 1);

    // Form feed with dv held high throughout the clear
    i_char    = 8'h0C;
    i_char_dv = 1'b1;
    tick();
    i_char = 8'h5A;
    expect_clear("t5");
    i_char_dv = 1'b0;
    tick();
    chk("t5_post_en", o_wr_en, 0);
    check_cur("t5_post", 0, 0);

    // Reset on the 10th clear write
    for (int i = 0; i < 3; i++) send(8'h43);
    send(8'h0C);
    for (int k = 0; k < 10; k++) tick();
    check_wr("t6_10th", 1, 'h20, 9, 0);
    i_rst = 1'b1;
    tick();
    chk("t6_en", o_wr_en, 0);
    chk("t6_busy", o_busy, 0);
    chk("t6_rdy", o_ready, 0);
    check_cur("t6", 0, 0);
    do_reset();
    send(8'h44);
    check_wr("t6_after", 1, 'h44, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
